// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants: instruction/PC widths and the queued entry.
package riscv_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int XLEN    = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        align_pc = {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with modulo-DEPTH pointers and an occupancy count.
module fetch_queue
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          enq,
    input  fetch_entry_t  enq_entry,
    input  logic          deq,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          enq_s;
    logic          deq_s;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = p + PW'(1);
        end
    endfunction

    // Guard both ports so a misbehaving producer/consumer cannot corrupt occupancy.
    always_comb begin
        deq_s = deq && (count_r != '0);
        enq_s = enq && ((count_r != CW'(DEPTH)) || deq_s);
    end

    // Storage, pointers and count; clear empties the queue and zeroes the head.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (enq_s) begin
                mem_r[wr_ptr_r] <= enq_entry;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (deq_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            count_r <= count_r + CW'(enq_s) - CW'(deq_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues PCs to instruction memory, queues responses, feeds decode.
// Optional same-cycle response bypass: INSTRUCTION_FETCH_BYPASS_EN.
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter int               DEPTH     = 4,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0,
    parameter int               MEM_BYTES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    output logic [XLEN-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               imem_stop,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic               halted
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_BYTES);

    logic [XLEN-1:0] fetch_pc_r;
    logic            issued_r;
    logic [XLEN-1:0] issued_pc_r;
    logic            halted_r;

    fetch_entry_t    q_head_s;
    fetch_entry_t    resp_entry_s;
    fetch_entry_t    out_entry_s;
    logic            q_empty_s;
    logic [CW-1:0]   q_count_s;
    logic            q_clr_n_s;
    logic            q_enq_s;
    logic            q_deq_s;
    logic            in_range_s;
    logic            stop_now_s;
    logic            resp_ok_s;
    logic            bypass_s;
    logic            deq_s;
    logic            issue_s;
    logic            unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Response routing, handshake and issue credit.
    always_comb begin
        in_range_s   = (fetch_pc_r < MEM_LIMIT);
        stop_now_s   = issued_r && imem_stop;
        resp_ok_s    = issued_r && !imem_stop && !redirect_valid;
        resp_entry_s = '{instr: imem_instr, pc: issued_pc_r};
`ifdef INSTRUCTION_FETCH_BYPASS_EN
        bypass_s     = q_empty_s && resp_ok_s;
`else
        bypass_s     = 1'b0;
`endif
        if (bypass_s) begin
            out_entry_s = resp_entry_s;
        end else begin
            out_entry_s = q_head_s;
        end
        out_valid = !q_empty_s || bypass_s;
        deq_s     = out_valid && out_ready;
        q_deq_s   = out_ready && !q_empty_s;
        q_enq_s   = resp_ok_s && !(bypass_s && out_ready);
        q_clr_n_s = rstn && !redirect_valid;
        // A stop word arriving this cycle blocks the next issue so nothing past it is fetched.
        issue_s   = !halted_r && !redirect_valid && !stop_now_s && in_range_s &&
                    ((int'(q_count_s) + int'(issued_r)) < (DEPTH + int'(deq_s)));
    end

    // Fetch PC, in-flight tracking and halt state; redirect overrides everything.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc_r  <= RESET_PC;
            issued_r    <= 1'b0;
            issued_pc_r <= '0;
            halted_r    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc_r <= align_pc(redirect_pc);
            issued_r   <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            issued_r <= issue_s;
            if (issue_s) begin
                issued_pc_r <= fetch_pc_r;
                fetch_pc_r  <= fetch_pc_r + 32'd4;
            end
            if (stop_now_s || (!issued_r && !in_range_s)) begin
                halted_r <= 1'b1;
            end
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .clr_n     (q_clr_n_s),
        .enq       (q_enq_s),
        .enq_entry (resp_entry_s),
        .deq       (q_deq_s),
        .head      (q_head_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

    assign imem_pc   = fetch_pc_r;
    assign out_instr = out_entry_s.instr;
    assign out_pc    = out_entry_s.pc;
    assign halted    = halted_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: per-cycle vector table plus multi-cycle sequences.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:255];

    // Instance A: RESET_PC = 0
    logic        rstn_a, ready_a, redir_v;
    logic [31:0] redir_pc;
    logic [31:0] imem_pc_a, resp_a, out_instr_a, out_pc_a;
    logic        out_valid_a, halted_a, stop_a;

    // Instance B: RESET_PC = 1020 (last word in range)
    logic        rstn_b, ready_b;
    logic [31:0] imem_pc_b, resp_b, out_instr_b, out_pc_b;
    logic        out_valid_b, halted_b, stop_b;

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0), .MEM_BYTES(1024)) dut_a (
        .clk(clk), .rstn(rstn_a), .imem_pc(imem_pc_a), .imem_instr(resp_a), .imem_stop(stop_a),
        .redirect_valid(redir_v), .redirect_pc(redir_pc), .out_valid(out_valid_a),
        .out_ready(ready_a), .out_instr(out_instr_a), .out_pc(out_pc_a), .halted(halted_a)
    );

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'd1020), .MEM_BYTES(1024)) dut_b (
        .clk(clk), .rstn(rstn_b), .imem_pc(imem_pc_b), .imem_instr(resp_b), .imem_stop(stop_b),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .out_valid(out_valid_b),
        .out_ready(ready_b), .out_instr(out_instr_b), .out_pc(out_pc_b), .halted(halted_b)
    );

    function automatic logic [31:0] mem_rd(input logic [31:0] pc);
        if (pc < 32'd1024) mem_rd = mem[pc[9:2]];
        else               mem_rd = 32'h0;
    endfunction

    // Registered memory model: word for the PC sampled at the previous edge.
    always @(posedge clk) begin
        resp_a <= mem_rd(imem_pc_a);
        resp_b <= mem_rd(imem_pc_b);
    end
    assign stop_a = (resp_a == 32'h0);
    assign stop_b = (resp_b == 32'h0);

    // Record every accepted instruction (handshake seen before the edge).
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    int          nb;
    logic [31:0] b_pc, b_instr;
    always @(negedge clk) begin
        if (rstn_a && out_valid_a && ready_a) begin
            got_pc.push_back(out_pc_a);
            got_instr.push_back(out_instr_a);
        end
        if (rstn_b && out_valid_b && ready_b) begin
            nb = nb + 1;
            b_pc = out_pc_b;
            b_instr = out_instr_b;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a(input logic rdy);
        rstn_a = 1'b0;
        ready_a = rdy;
        step();
        rstn_a = 1'b1;
    endtask

    typedef struct {
        logic        rdy;
        logic        v;
        logic        h;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
    } vec_t;

    vec_t tbl [6];
    int   n12;

    initial begin
        nb = 0;
        b_pc = 32'h0;
        b_instr = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h00600113;
        mem[1]   = 32'h00100093;
        mem[255] = 32'h00a00193;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
`ifdef INSTRUCTION_FETCH_BYPASS_EN
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h00600113, 32'h4};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h4, 32'h00100093, 32'h8};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hc};
`else
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h4};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 32'h00600113, 32'h8};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h4, 32'h00100093, 32'hc};
`endif
        tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hc};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hc};

        rstn_a = 1'b0; rstn_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        redir_v = 1'b0; redir_pc = 32'h0;
        step();
        step();

        // Vector table: reset state then per-cycle stop-word sequence.
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                rstn_a = 1'b1;
                rstn_b = 1'b1;
            end
            ready_a = tbl[i].rdy;
            if (i > 0) step();
            chk($sformatf("t1_valid[%0d]", i), {31'h0, out_valid_a}, {31'h0, tbl[i].v});
            chk($sformatf("t1_halted[%0d]", i), {31'h0, halted_a}, {31'h0, tbl[i].h});
            chk($sformatf("t1_imem_pc[%0d]", i), imem_pc_a, tbl[i].ipc);
            if (tbl[i].v || i == 0) begin
                chk($sformatf("t1_pc[%0d]", i), out_pc_a, tbl[i].pc);
                chk($sformatf("t1_instr[%0d]", i), out_instr_a, tbl[i].instr);
            end
        end

        // Instance B: single in-range word, then range halt at 1024.
        chk("b_count", nb, 32'd1);
        chk("b_pc", b_pc, 32'd1020);
        chk("b_instr", b_instr, 32'h00a00193);
        chk("b_halted", {31'h0, halted_b}, 32'h1);
        chk("b_imem_pc", imem_pc_b, 32'd1024);

        // Stall: queue fills to DEPTH, fetch freezes at 16, drains in order.
        for (int i = 0; i < 64; i++) mem[i] = 32'ha000_0000 | i;
        reset_a(1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("stall_valid", {31'h0, out_valid_a}, 32'h1);
        chk("stall_pc", out_pc_a, 32'h0);
        chk("stall_instr", out_instr_a, 32'ha000_0000);
        chk("stall_imem_pc", imem_pc_a, 32'd16);
        got_pc.delete();
        got_instr.delete();
        ready_a = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_count", got_pc.size(), 32'd4);
        if (got_pc.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("drain_pc[%0d]", i), got_pc[i], 32'(4 * i));
                chk($sformatf("drain_instr[%0d]", i), got_instr[i], 32'ha000_0000 | i);
            end
        end

        // Redirect with queue credit exhausted and a request in flight.
        reset_a(1'b0);
        for (int i = 0; i < 4; i++) step();
        redir_v = 1'b1;
        redir_pc = 32'h00000042;
        step();
        redir_v = 1'b0;
        chk("redir_valid", {31'h0, out_valid_a}, 32'h0);
        chk("redir_imem_pc", imem_pc_a, 32'h40);
        got_pc.delete();
        got_instr.delete();
        ready_a = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("redir_seen", {31'h0, got_pc.size() > 0}, 32'h1);
        if (got_pc.size() > 0) begin
            chk("redir_first_pc", got_pc[0], 32'h40);
            chk("redir_first_instr", got_instr[0], 32'ha000_0010);
        end
        n12 = 0;
        foreach (got_pc[k]) if (got_pc[k] == 32'hc) n12++;
        chk("redir_inflight_dropped", n12, 32'd0);

        // Mid-stream reset for one cycle.
        reset_a(1'b1);
        for (int i = 0; i < 6; i++) step();
        rstn_a = 1'b0;
        step();
        chk("mrst_valid", {31'h0, out_valid_a}, 32'h0);
        chk("mrst_imem_pc", imem_pc_a, 32'h0);
        chk("mrst_halted", {31'h0, halted_a}, 32'h0);
        rstn_a = 1'b1;
        got_pc.delete();
        got_instr.delete();
        for (int i = 0; i < 5; i++) step();
        chk("mrst_seen", {31'h0, got_pc.size() > 0}, 32'h1);
        if (got_pc.size() > 0) chk("mrst_first_pc", got_pc[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
